// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage for a classic in-order pipeline. It issues one
// request at a time on a split address/data instruction bus, tracks the PC
// of the outstanding request, and holds the returned word in a one-entry
// buffer that the ID stage drains. Branch/exception redirects override
// sequential fetch. If a redirect arrives while a transaction is still
// outstanding, the stale return is marked for discard so that it never
// reaches the buffer.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : asynchronous active-high reset
//   if_id_stall_i  : ID stage will not take the buffered instruction
//   redirect_i     : redirect request, overrides sequential fetch
//   redirect_pc_i  : redirect target, used only while redirect_i is high
//   inst_req_o     : instruction bus request
//   inst_addr_o    : request address (meaningful while inst_req_o is high)
//   inst_addr_ok_i : bus accepted the request this cycle
//   inst_data_ok_i : bus returned read data this cycle
//   inst_rdata_i   : returned instruction word
//   if_valid_o     : buffer holds a valid instruction
//   if_pc_o        : PC of the buffered instruction
//   if_inst_o      : buffered instruction word
//   if_stall_o     : fetch not ready (buffer empty outside IDLE)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_stall_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] next_pc;
  logic [31:0] inflight_pc;
  logic        discard;

  logic        consume;
  logic        redirect_active;
  logic        issue;
  logic        accept;
  logic        data_ret;
  logic        fill;
  logic [31:0] issue_addr;
  logic [31:0] issue_addr_plus4;

  // Decoded events for the current cycle. A redirect is ignored in IDLE
  // because nothing has been fetched yet and the reset PC is still pending.
  assign consume          = if_valid_o & ~if_id_stall_i;
  assign redirect_active  = redirect_i & (state != ST_IDLE);
  assign issue_addr       = redirect_i ? redirect_pc_i : next_pc;
  assign issue_addr_plus4 = issue_addr + 32'd4;

  // A request is only raised when the buffer will have room by the time the
  // data comes back: either it is empty now or it is being drained now. This
  // guarantees the buffer is empty for the whole of WAIT.
  assign issue    = (state == ST_REQ) & (~if_valid_o | consume);
  assign accept   = issue & inst_addr_ok_i;
  assign data_ret = (state == ST_WAIT) & inst_data_ok_i;

  // Returned data is kept only if no redirect has made it stale, either in
  // an earlier cycle (discard) or in this very cycle (redirect_i).
  assign fill = data_ret & ~discard & ~redirect_i;

  assign inst_req_o  = issue;
  assign inst_addr_o = (state == ST_REQ) ? issue_addr : next_pc;
  assign if_stall_o  = (state != ST_IDLE) & ~if_valid_o;

  // Next-state decode: leave IDLE on the first edge after reset, move to
  // WAIT once the bus accepts an address, back to REQ when the data returns.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (accept)   state_nxt = ST_WAIT;
      ST_WAIT: if (data_ret) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC tracking. An accepted request always advances from the address
  // actually issued, which already includes a same-cycle redirect target, so
  // the accept case has priority over the plain redirect case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc     <= RESET_PC;
      inflight_pc <= RESET_PC;
    end else begin
      if (accept) begin
        next_pc     <= issue_addr_plus4;
        inflight_pc <= issue_addr;
      end else if (redirect_active) begin
        next_pc <= redirect_pc_i;
      end
    end
  end

  // Discard flag. Set when a redirect hits while a transaction is still
  // outstanding; cleared when that transaction's data finally returns. A
  // redirect coinciding with the data return needs no flag because the
  // returned word is dropped directly through the fill gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= 1'b0;
    end else begin
      if (data_ret) begin
        discard <= 1'b0;
      end else if ((state == ST_WAIT) && redirect_i) begin
        discard <= 1'b1;
      end
    end
  end

  // Output buffer. A redirect flushes the buffered instruction, a fresh
  // return fills it, and an ID-stage take empties it. Fill and consume never
  // coincide because the buffer is empty in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= RESET_PC;
      if_inst_o  <= 32'd0;
    end else begin
      if (redirect_active) begin
        if_valid_o <= 1'b0;
      end else if (fill) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= inflight_pc;
        if_inst_o  <= inst_rdata_i;
      end else if (consume) begin
        if_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit. A table of per-cycle records drives the
// bus handshake, stall and redirect inputs and lists the outputs expected in
// that cycle (sampled mid low phase, before the next rising edge). Reset
// behaviour, including an asynchronous reset in WAIT, is exercised by
// hand-written sequences around the table.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        if_id_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_stall_o;

  int checks;
  int fails;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  ifetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_id_stall_i  (if_id_stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .if_stall_o     (if_stall_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Address is compared only while a request is expected, and pc/inst only
  // while the buffer is expected valid.
  task automatic checkOutput(input string tag, input vec_t v);
    checkWord({tag, ".req"},   {31'd0, inst_req_o}, {31'd0, v.exp_req});
    checkWord({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, v.exp_valid});
    checkWord({tag, ".stall"}, {31'd0, if_stall_o}, {31'd0, v.exp_stall});
    if (v.exp_req) checkWord({tag, ".addr"}, inst_addr_o, v.exp_addr);
    if (v.exp_valid) begin
      checkWord({tag, ".pc"},   if_pc_o,   v.exp_pc);
      checkWord({tag, ".inst"}, if_inst_o, v.exp_inst);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    if_id_stall_i  = v.stall;
    redirect_i     = v.redir;
    redirect_pc_i  = v.redir_pc;
    inst_addr_ok_i = v.addr_ok;
    inst_data_ok_i = v.data_ok;
    inst_rdata_i   = v.rdata;
    #1;
  endtask

  task automatic addVec(input logic stall, input logic redir, input logic [31:0] redir_pc,
                        input logic addr_ok, input logic data_ok, input logic [31:0] rdata,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic exp_valid, input logic [31:0] exp_pc,
                        input logic [31:0] exp_inst, input logic exp_stall);
    vec_t v;
    v.stall = stall;      v.redir = redir;       v.redir_pc = redir_pc;
    v.addr_ok = addr_ok;  v.data_ok = data_ok;   v.rdata = rdata;
    v.exp_req = exp_req;  v.exp_addr = exp_addr; v.exp_valid = exp_valid;
    v.exp_pc = exp_pc;    v.exp_inst = exp_inst; v.exp_stall = exp_stall;
    vecs.push_back(v);
  endtask

  task automatic checkResetValues(input string tag);
    checkWord({tag, ".req"},   {31'd0, inst_req_o}, 32'd0);
    checkWord({tag, ".addr"},  inst_addr_o,         32'hBFC0_0000);
    checkWord({tag, ".valid"}, {31'd0, if_valid_o}, 32'd0);
    checkWord({tag, ".pc"},    if_pc_o,             32'hBFC0_0000);
    checkWord({tag, ".inst"},  if_inst_o,           32'd0);
    checkWord({tag, ".stall"}, {31'd0, if_stall_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    fails  = 0;

    //     stall redir target        aok dok rdata          req addr           vld pc             inst           stl
    // Reset fetch: request shown, accepted one cycle later, data next cycle.
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hBFC0_0000, 0, 32'h0,          32'h0,          1); // 0
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hBFC0_0000, 0, 32'h0,          32'h0,          1); // 1
    addVec(0, 0, 32'h0,          0, 1, 32'h1111_1111,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 2
    // Buffer full and ID stalled for five cycles: no request, buffer stable.
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'hBFC0_0000,  32'h1111_1111,  0); // 3
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'hBFC0_0000,  32'h1111_1111,  0); // 4
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'hBFC0_0000,  32'h1111_1111,  0); // 5
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'hBFC0_0000,  32'h1111_1111,  0); // 6
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'hBFC0_0000,  32'h1111_1111,  0); // 7
    // Stall drops: request for pc+4 in the consume cycle, accepted.
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hBFC0_0004, 1, 32'hBFC0_0000,  32'h1111_1111,  0); // 8
    // Redirect while waiting for BFC00004; stale word returns next cycle.
    addVec(0, 1, 32'h8000_1000,  0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0,          1); // 9
    addVec(0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 10
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_1000, 0, 32'h0,          32'h0,          1); // 11
    addVec(0, 0, 32'h0,          0, 1, 32'h2222_2222,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 12
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_1004, 1, 32'h8000_1000,  32'h2222_2222,  0); // 13
    // Redirect and data return in the same WAIT cycle: data dropped.
    addVec(0, 1, 32'hFFFF_FFFC,  0, 1, 32'h3333_3333,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 14
    // Request held four cycles without acceptance; stray data_ok in REQ ignored.
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,          1); // 15
    addVec(0, 0, 32'h0,          0, 1, 32'h7777_7777,  1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,          1); // 16
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,          1); // 17
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,          1); // 18
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0,          1); // 19
    addVec(0, 0, 32'h0,          0, 1, 32'h4444_4444,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 20
    // Next PC wrapped to zero; consume without acceptance.
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'hFFFF_FFFC,  32'h4444_4444,  0); // 21
    // Redirect in REQ accepted in the same cycle.
    addVec(0, 1, 32'h0040_0000,  1, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0,          32'h0,          1); // 22
    addVec(0, 0, 32'h0,          0, 1, 32'h5555_5555,  0, 32'h0,         0, 32'h0,          32'h0,          1); // 23
    // Redirect while buffer full and ID stalled: buffer flushed.
    addVec(1, 1, 32'h0050_0000,  0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0000,  32'h5555_5555,  0); // 24
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0050_0000, 0, 32'h0,          32'h0,          1); // 25
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0,          1); // 26

    // Reset state.
    rst            = 1'b1;
    if_id_stall_i  = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'h0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = 32'h0;
    #2;
    checkResetValues("reset");

    // Release; one IDLE cycle with no request and no stall.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkWord("idle.req",   {31'd0, inst_req_o}, 32'd0);
    checkWord("idle.stall", {31'd0, if_stall_o}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      checkOutput($sformatf("v%0d", i), v);
    end

    // Asynchronous reset while waiting for data, mid low phase.
    @(negedge clk);
    inst_data_ok_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("async_rst");

    // Stray data_ok for the aborted transaction, during and after reset.
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'h6666_6666;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkWord("post_rst_idle.valid", {31'd0, if_valid_o}, 32'd0);
    @(negedge clk);
    inst_data_ok_i = 1'b0;
    #1;
    checkWord("post_rst.valid", {31'd0, if_valid_o}, 32'd0);
    checkWord("post_rst.inst",  if_inst_o,           32'd0);
    checkWord("post_rst.req",   {31'd0, inst_req_o}, 32'd1);
    checkWord("post_rst.addr",  inst_addr_o,         32'hBFC0_0000);
    checkWord("post_rst.stall", {31'd0, if_stall_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
